// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, control FSM
// states and the mux/ALU select codes that the datapath decodes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    RESET_S,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    WB_ALU,
    ADDR,
    MEM_RD,
    WB_MEM,
    MEM_WR,
    BRANCH,
    JAL,
    HALT
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_BRANCH = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'd0;
  localparam logic [1:0] SRC_A_RS1   = 2'd1;
  localparam logic [1:0] SRC_A_OLDPC = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  // Register file write data select
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/riscv_cycle_counter.sv
// Saturating up-counter used to report elapsed cycles; stops at all-ones
// rather than wrapping, and holds while frozen.
module riscv_cycle_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count enabled, unfrozen cycles until the all-ones ceiling
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (enable && !freeze && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I CPU. Steps the shared datapath
// through fetch/decode/execute/memory/writeback one instruction at a time and
// halts (done) on ECALL or an unknown opcode.
module riscv_multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] clock_count
);

  state_t state;
  logic   illegal_q;

  // State register plus the sticky illegal-opcode flag captured at decode
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RESET_S;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        RESET_S: state <= FETCH;
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R:                state <= EXEC_R;
            OP_I:                state <= EXEC_I;
            OP_LOAD, OP_STORE:   state <= ADDR;
            OP_BRANCH:           state <= BRANCH;
            OP_JAL:              state <= JAL;
            OP_SYSTEM:           state <= HALT;
            default: begin
              state     <= HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        EXEC_R:  state <= WB_ALU;
        EXEC_I:  state <= WB_ALU;
        WB_ALU:  state <= FETCH;
        ADDR:    state <= (opcode == OP_STORE) ? MEM_WR : MEM_RD;
        MEM_RD:  if (mem_ready) state <= WB_MEM;
        WB_MEM:  state <= FETCH;
        MEM_WR:  if (mem_ready) state <= FETCH;
        BRANCH:  state <= FETCH;
        JAL:     state <= FETCH;
        HALT:    state <= HALT;
        default: state <= RESET_S;
      endcase
    end
  end

  // Control decode from the state register; only the fetch write enables
  // (mem_ready) and the branch PC load (branch_taken) look at inputs, so an
  // async reset of the state removes mem_req immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RS2;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    case (state)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
      end
      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
      end
      WB_ALU: reg_write = 1'b1;
      ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_BRANCH;
        pc_write  = branch_taken;
        pc_src    = 1'b1;
      end
      JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
      end
      default: ;
    endcase
  end

  assign done    = (state == HALT);
  assign illegal = illegal_q;

  riscv_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .freeze (done),
    .count  (clock_count)
  );

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: instructions are expanded into per-cycle
// {inputs, expected outputs} records and replayed against a 32-bit and a
// 4-bit-counter instance.
module tb_riscv_multicycle_ctrl;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_I      = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, done, illegal;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [31:0] clock_count;

  logic        s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_pc_src, s_reg_write, s_done, s_illegal;
  logic [1:0]  s_alu_src_a, s_alu_src_b, s_alu_op, s_wb_sel;
  logic [3:0]  s_clock_count;

  riscv_multicycle_ctrl #(.CNT_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .done(done), .illegal(illegal),
    .clock_count(clock_count)
  );

  riscv_multicycle_ctrl #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(s_mem_req), .mem_we(s_mem_we), .iord(s_iord),
    .ir_write(s_ir_write), .pc_write(s_pc_write), .pc_src(s_pc_src),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
    .reg_write(s_reg_write), .wb_sel(s_wb_sel), .done(s_done), .illegal(s_illegal),
    .clock_count(s_clock_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       reg_write;
    logic [1:0] wb;
    logic       done;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic       rdy;
    logic       tk;
    outs_t      exp;
  } vec_t;

  outs_t got, got_s;
  assign got   = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                  alu_op, reg_write, wb_sel, done, illegal};
  assign got_s = {s_mem_req, s_mem_we, s_iord, s_ir_write, s_pc_write, s_pc_src, s_alu_src_a,
                  s_alu_src_b, s_alu_op, s_reg_write, s_wb_sel, s_done, s_illegal};

  vec_t        vq[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_cnt = 0;
  logic        prev_done = 1'b0;

  // Expected control word for one named step of an instruction
  function automatic outs_t step_out(input string s, input logic tk, input logic ill);
    outs_t r;
    r = '0;
    case (s)
      "fetch_wait": begin r.mem_req = 1; r.b = 2'd1; end
      "fetch":      begin r.mem_req = 1; r.b = 2'd1; r.ir_write = 1; r.pc_write = 1; end
      "decode":     begin r.a = 2'd2; r.b = 2'd2; end
      "exec_r":     begin r.a = 2'd1; r.b = 2'd0; r.op = 2'd2; end
      "exec_i":     begin r.a = 2'd1; r.b = 2'd2; r.op = 2'd2; end
      "wb_alu":     begin r.reg_write = 1; r.wb = 2'd0; end
      "addr":       begin r.a = 2'd1; r.b = 2'd2; end
      "mem_rd":     begin r.mem_req = 1; r.iord = 1; end
      "wb_mem":     begin r.reg_write = 1; r.wb = 2'd1; end
      "mem_wr":     begin r.mem_req = 1; r.mem_we = 1; r.iord = 1; end
      "branch":     begin r.a = 2'd1; r.b = 2'd0; r.op = 2'd1; r.pc_src = 1; r.pc_write = tk; end
      "jal":        begin r.reg_write = 1; r.wb = 2'd2; r.pc_write = 1; r.pc_src = 1; end
      "halt":       begin r.done = 1; r.illegal = ill; end
      default:      r = '0;
    endcase
    return r;
  endfunction

  task automatic push(input string s, input logic [6:0] opc, input logic rdy, input logic tk,
                      input logic ill);
    vec_t v;
    v.name = s;
    v.opc  = opc;
    v.rdy  = rdy;
    v.tk   = tk;
    v.exp  = step_out(s, tk, ill);
    vq.push_back(v);
  endtask

  function automatic logic rbit();
    return 1'($urandom());
  endfunction

  // Expand one instruction into its cycle-by-cycle records
  task automatic add_instr(input logic [6:0] op, input int unsigned wf, input int unsigned wm,
                           input logic tk, input int unsigned nhalt);
    for (int unsigned i = 0; i < wf; i++) push("fetch_wait", 7'($urandom()), 1'b0, rbit(), 1'b0);
    push("fetch", 7'($urandom()), 1'b1, rbit(), 1'b0);
    push("decode", op, rbit(), rbit(), 1'b0);
    case (op)
      T_R:      begin push("exec_r", op, rbit(), rbit(), 0); push("wb_alu", op, rbit(), rbit(), 0); end
      T_I:      begin push("exec_i", op, rbit(), rbit(), 0); push("wb_alu", op, rbit(), rbit(), 0); end
      T_LOAD: begin
        push("addr", op, rbit(), rbit(), 0);
        for (int unsigned i = 0; i < wm; i++) push("mem_rd", op, 1'b0, rbit(), 0);
        push("mem_rd", op, 1'b1, rbit(), 0);
        push("wb_mem", op, rbit(), rbit(), 0);
      end
      T_STORE: begin
        push("addr", op, rbit(), rbit(), 0);
        for (int unsigned i = 0; i < wm; i++) push("mem_wr", op, 1'b0, rbit(), 0);
        push("mem_wr", op, 1'b1, rbit(), 0);
      end
      T_BRANCH: push("branch", op, rbit(), tk, 0);
      T_JAL:    push("jal", op, rbit(), rbit(), 0);
      T_SYSTEM: for (int unsigned i = 0; i < nhalt; i++) push("halt", op, rbit(), rbit(), 1'b0);
      default:  for (int unsigned i = 0; i < nhalt; i++) push("halt", op, rbit(), rbit(), 1'b1);
    endcase
  endtask

  task automatic check_outs(input string nm, input outs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: controls got=%h required=%h", nm, got, exp);
    end
    checks++;
    if (got_s !== exp) begin
      errors++;
      $display("FAIL %s (cnt4 instance): controls got=%h required=%h", nm, got_s, exp);
    end
  endtask

  task automatic check_cnt(input string nm);
    logic [3:0] exp_s;
    exp_s = (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt);
    checks++;
    if (clock_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s: clock_count got=%0d required=%0d", nm, clock_count, exp_cnt);
    end
    checks++;
    if (s_clock_count !== exp_s) begin
      errors++;
      $display("FAIL %s: 4-bit clock_count got=%0d required=%0d", nm, s_clock_count, exp_s);
    end
  endtask

  // Replay queued records: drive just after the rising edge, check on the falling edge
  task automatic run_queue();
    vec_t v;
    while (vq.size() > 0) begin
      v = vq.pop_front();
      @(posedge clock);
      if (!prev_done) exp_cnt++;
      #1;
      opcode       = v.opc;
      mem_ready    = v.rdy;
      branch_taken = v.tk;
      @(negedge clock);
      check_outs(v.name, v.exp);
      check_cnt(v.name);
      prev_done = v.exp.done;
    end
  endtask

  // Hold reset for three cycles, release, and check the RESET_S cycle
  task automatic do_reset();
    @(posedge clock);
    #1;
    reset        = 1'b1;
    mem_ready    = 1'b1;
    branch_taken = 1'b1;
    opcode       = T_R;
    exp_cnt      = 0;
    prev_done    = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clock);
      check_outs("in_reset", '0);
      check_cnt("in_reset");
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_outs("reset_s", '0);
    check_cnt("reset_s");
  endtask

  logic [6:0] rop;
  logic [6:0] ops[6];

  initial begin
    ops[0] = T_R; ops[1] = T_I; ops[2] = T_LOAD; ops[3] = T_STORE; ops[4] = T_BRANCH; ops[5] = T_JAL;

    // Directed program: R zero-wait, load 3/3 waits, branch taken/not, I, store, jal, ecall
    do_reset();
    add_instr(T_R, 0, 0, 1'b0, 0);
    add_instr(T_LOAD, 3, 3, 1'b0, 0);
    add_instr(T_BRANCH, 0, 0, 1'b1, 0);
    add_instr(T_BRANCH, 0, 0, 1'b0, 0);
    add_instr(T_I, 1, 0, 1'b0, 0);
    add_instr(T_STORE, 0, 2, 1'b0, 0);
    add_instr(T_JAL, 2, 0, 1'b0, 0);
    add_instr(T_SYSTEM, 0, 0, 1'b0, 5);
    run_queue();

    // Illegal opcode halts with illegal set; counter frozen for 20 cycles
    do_reset();
    add_instr(T_R, 0, 0, 1'b0, 0);
    add_instr(7'b1111111, 0, 0, 1'b0, 20);
    run_queue();

    // Reset in the middle of a halted illegal state clears done/illegal at once
    #2 reset = 1'b1;
    #1;
    check_outs("async_reset_halt", '0);
    exp_cnt = 0;
    check_cnt("async_reset_halt");

    // Random instruction stream with random waits, ending in an unknown opcode
    do_reset();
    for (int unsigned n = 0; n < 150; n++)
      add_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), rbit(), 0);
    rop = 7'($urandom());
    if (rop == T_R || rop == T_I || rop == T_LOAD || rop == T_STORE || rop == T_BRANCH ||
        rop == T_JAL || rop == T_SYSTEM)
      rop = 7'b0001011;
    add_instr(rop, 1, 0, 1'b0, 10);
    run_queue();

    // Reset while a store is still waiting for memory
    do_reset();
    add_instr(T_R, 0, 0, 1'b0, 0);
    add_instr(T_STORE, 0, 6, 1'b0, 0);
    void'(vq.pop_back());
    run_queue();
    #2 reset = 1'b1;
    #1;
    check_outs("async_reset_mem_wr", '0);
    exp_cnt = 0;
    check_cnt("async_reset_mem_wr");

    // Restart from FETCH after that reset
    do_reset();
    add_instr(T_JAL, 0, 0, 1'b0, 0);
    add_instr(T_R, 0, 0, 1'b0, 0);
    run_queue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
